// File: rtl/min_distance_selector_if.sv
// min_distance_selector_if: control, result and distance-store signals of the next-node selector
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 3
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif
interface min_distance_selector_if #(
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
);
    logic                   start;
    logic                   clear;
    logic                   mark_en;
    logic [INDEX_WIDTH-1:0] mark_index;
    logic                   busy;
    logic                   done;
    logic                   found;
    logic [INDEX_WIDTH-1:0] min_index;
    logic [VALUE_WIDTH-1:0] min_value;
    logic                   store_get_en;
    logic [INDEX_WIDTH-1:0] store_index;
    logic [VALUE_WIDTH-1:0] store_value;
    modport slave (
        input  start, clear, mark_en, mark_index, store_value,
        output busy, done, found, min_index, min_value, store_get_en, store_index
    );
    modport master (
        output start, clear, mark_en, mark_index, store_value,
        input  busy, done, found, min_index, min_value, store_get_en, store_index
    );
endinterface

// File: rtl/min_distance_selector.sv
// min_distance_selector: scans all nodes and returns the unvisited one with the smallest finite distance (MINSEL_SKIP_VISITED_EN suppresses reads of visited nodes)
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 3
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif
module min_distance_selector #(
    parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
    input logic                   clock,
    input logic                   reset,
    min_distance_selector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
    state_t                 state_q;
    logic [MAX_NODES-1:0]   visited_q, visited_d, snap_q;
    logic [INDEX_WIDTH-1:0] idx_q, nxt_idx, pend_idx_q, min_index_q;
    logic [VALUE_WIDTH-1:0] min_value_q;
    logic                   get_en_q, pend_vld_q, found_q, busy_q, done_q;
    logic                   mark_ok, hit, last, first_en, nxt_en;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.found        = found_q;
    assign bus.min_index    = min_index_q;
    assign bus.min_value    = min_value_q;
    assign bus.store_get_en = get_en_q;
    assign bus.store_index  = idx_q;
    // live bitmap update, compare qualification and next-read enable
    always_comb begin
        mark_ok   = bus.mark_en && (32'(bus.mark_index) < MAX_NODES);
        visited_d = bus.clear ? '0 : visited_q | (mark_ok ? (MAX_NODES'(1) << bus.mark_index) : '0);
        nxt_idx   = idx_q + INDEX_WIDTH'(1);
        last      = idx_q == INDEX_WIDTH'(MAX_NODES - 1);
        hit       = pend_vld_q && ~|(snap_q & (MAX_NODES'(1) << pend_idx_q))
                    && bus.store_value != '1 && bus.store_value < min_value_q;
`ifdef MINSEL_SKIP_VISITED_EN
        first_en  = !visited_q[0];
        nxt_en    = ~|(snap_q & (MAX_NODES'(1) << nxt_idx));
`else
        first_en  = 1'b1;
        nxt_en    = 1'b1;
`endif
    end
    // scan FSM: issue one index per cycle, compare one cycle later, pulse done after the last compare
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            visited_q   <= '0;
            snap_q      <= '0;
            idx_q       <= '0;
            get_en_q    <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            min_index_q <= '0;
            min_value_q <= '1;
            found_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            visited_q  <= visited_d;
            done_q     <= 1'b0;
            pend_vld_q <= state_q == SCAN;
            pend_idx_q <= idx_q;
            if (hit) begin
                min_value_q <= bus.store_value;
                min_index_q <= pend_idx_q;
                found_q     <= 1'b1;
            end
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q     <= SCAN;
                    busy_q      <= 1'b1;
                    snap_q      <= visited_q;
                    min_value_q <= '1;
                    min_index_q <= '0;
                    found_q     <= 1'b0;
                    idx_q       <= '0;
                    get_en_q    <= first_en;
                end
                SCAN: if (last) begin
                    state_q  <= DRAIN;
                    get_en_q <= 1'b0;
                end else begin
                    idx_q    <= nxt_idx;
                    get_en_q <= nxt_en;
                end
                DRAIN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_min_distance_selector.sv
// tb_min_distance_selector: randomized scoreboard bench for the next-node selector
module tb_min_distance_selector;
    localparam int N  = 8;
    localparam int IW = 4;
    localparam int VW = 8;
    typedef struct {
        logic          f;
        logic [IW-1:0] i;
        logic [VW-1:0] v;
        int            c;
    } exp_t;
    logic clock, reset;
    logic [VW-1:0] mem [N];
    logic [N-1:0]  vis;
    exp_t sb[$];
    int total, bad, cyc, dones, accepted;
    min_distance_selector_if #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) bus();
    min_distance_selector #(.MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    // distance store: data appears the cycle after the strobe, junk otherwise
    always @(posedge clock)
        bus.store_value <= bus.store_get_en ? mem[bus.store_index[2:0]] : VW'($urandom);
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask
    // reference: smallest finite unvisited value, first index holding it
    function automatic exp_t model(input logic [N-1:0] snap);
        exp_t e;
        int vals[$];
        int mn[$];
        e.f = 1'b0; e.i = '0; e.v = '1; e.c = 0;
        for (int i = 0; i < N; i++)
            if (!snap[i] && mem[i] != '1) vals.push_back(int'(mem[i]));
        if (vals.size() > 0) begin
            mn = vals.min();
            for (int i = N - 1; i >= 0; i--)
                if (!snap[i] && int'(mem[i]) == mn[0]) e.i = IW'(i);
            e.f = 1'b1;
            e.v = VW'(mn[0]);
        end
        return e;
    endfunction
    // monitor: every done pulse pops and checks one expected result
    always @(negedge clock) begin
        if (bus.done) begin
            exp_t e;
            dones++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                check("found", bus.found, e.f);
                check("min_index", bus.min_index, e.i);
                check("min_value", bus.min_value, e.v);
                check("done_cycle", cyc, e.c);
            end
        end
    end
    task automatic mark(input int i);
        @(negedge clock);
        bus.mark_en = 1'b1;
        bus.mark_index = IW'(i);
        if (i < N) vis[i] = 1'b1;
        @(negedge clock);
        bus.mark_en = 1'b0;
    endtask
    task automatic clr(input bit with_mark);
        @(negedge clock);
        bus.clear = 1'b1;
        bus.mark_en = with_mark;
        bus.mark_index = IW'(5);
        vis = '0;
        @(negedge clock);
        bus.clear = 1'b0;
        bus.mark_en = 1'b0;
    endtask
    task automatic load(input logic [VW-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3;
        mem[4] = a4; mem[5] = a5; mem[6] = a6; mem[7] = a7;
    endtask
    task automatic do_scan(input bit hold, input int mark_at, input int abort_at);
        logic [N-1:0] snap;
        exp_t e;
        bit en;
        snap = vis;
        e = model(snap);
        @(negedge clock);
        bus.start = 1'b1;
        e.c = cyc + N + 2;
        sb.push_back(e);
        accepted++;
        for (int k = 0; k < N; k++) begin
            @(negedge clock);
            if (!hold) bus.start = 1'b0;
            bus.mark_en = 1'b0;
            if (k == abort_at) begin
                reset = 1'b0;
                bus.start = 1'b0;
                #1;
                check("abort_busy", bus.busy, 0);
                check("abort_done", bus.done, 0);
                check("abort_get_en", bus.store_get_en, 0);
                check("abort_min_value", bus.min_value, 32'hff);
                void'(sb.pop_back());
                accepted--;
                vis = '0;
                @(negedge clock);
                reset = 1'b1;
                return;
            end
`ifdef MINSEL_SKIP_VISITED_EN
            en = !snap[k];
`else
            en = 1'b1;
`endif
            check("issue_index", bus.store_index, k);
            check("issue_get_en", bus.store_get_en, en);
            check("scan_busy", bus.busy, 1);
            if (k == mark_at) begin
                bus.mark_en = 1'b1;
                bus.mark_index = '0;
                vis[0] = 1'b1;
            end
        end
        @(negedge clock);
        bus.mark_en = 1'b0;
        check("drain_get_en", bus.store_get_en, 0);
        check("drain_busy", bus.busy, 1);
        check("drain_done", bus.done, 0);
        @(negedge clock);
        check("done_pulse", bus.done, 1);
        check("done_busy", bus.busy, 0);
        @(negedge clock);
        bus.start = 1'b0;
        check("done_single", bus.done, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
    initial begin
        int d0;
        bus.start = 1'b0; bus.clear = 1'b0; bus.mark_en = 1'b0; bus.mark_index = '0;
        vis = '0;
        load(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_found", bus.found, 0);
        check("rst_min_index", bus.min_index, 0);
        check("rst_min_value", bus.min_value, 32'hff);
        check("rst_get_en", bus.store_get_en, 0);
        check("rst_store_index", bus.store_index, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        load(5, 3, 9, 3, 8'hff, 8'hff, 8'hff, 8'hff);
        do_scan(0, -1, -1);
        repeat (3) @(negedge clock);
        check("hold_found", bus.found, 1);
        check("hold_min_index", bus.min_index, 1);
        check("hold_min_value", bus.min_value, 3);
        mark(1);
        mark(3);
        do_scan(0, -1, -1);
        load(8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff);
        clr(0);
        do_scan(0, -1, -1);
        load(7, 6, 5, 4, 3, 2, 1, 0);
        for (int i = 0; i < N; i++) mark(i);
        mark(9);
        do_scan(0, -1, -1);
        clr(0);
        load(2, 4, 1, 1, 8'hff, 0, 9, 8'hfe);
        do_scan(0, 3, -1);
        do_scan(0, -1, -1);
        clr(1);
        load(4, 4, 4, 4, 4, 0, 4, 4);
        do_scan(0, -1, -1);
        mark(1);
        mark(3);
        load(5, 3, 9, 3, 8'hff, 8'hff, 8'hff, 8'hff);
        d0 = dones;
        do_scan(0, -1, 4);
        repeat (12) @(negedge clock);
        check("abort_no_done", dones, d0);
        check("abort_rst_found", bus.found, 0);
        do_scan(0, -1, -1);
        do_scan(1, -1, -1);
        repeat (2) @(negedge clock);
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? 8'hff : VW'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) clr($urandom_range(0, 1) == 1);
            for (int m = $urandom_range(0, 2); m > 0; m--) mark($urandom_range(0, 11));
            do_scan($urandom_range(0, 3) == 0, ($urandom_range(0, 3) == 0) ? 2 : -1, -1);
        end
        repeat (3) @(negedge clock);
        check("sb_empty", sb.size(), 0);
        check("done_count", dones, accepted);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
